axi4_sub_mem: RTL and testbench
===============================

# axi4_sub_mem

AXI4 subordinate backed by an internal word-addressed flop memory. It is the downstream stage of the team's AXI4 manager and is the target for that manager in block and integration benches. It also serves as a small scratch RAM on the interconnect. Write and read channels run independent FSMs and support single-beat and INCR bursts at full data width, with SLVERR reporting for out-of-range or unsupported accesses.

## Interface
- AXI_ADDR_WIDTH, 32, address width of `axi_sub_if`.
- AXI_DATA_WIDTH, 64, data width; bytes per beat BPB = AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 4, ID width of `axi_sub_if`.
- MEM_DEPTH, 256, number of AXI_DATA_WIDTH-bit words.
- BASE_ADDR, 0, byte address of word 0; must be BPB-aligned.
- clk_i  input  1  clock; all logic on rising edge.
- rstn_i  input  1  reset; asynchronous, active-low.
- axi_sub_if  AXI_BUS.Slave  —  full AXI4 subordinate port (AW/W/B/AR/R).

## Operation
- Word index = (addr − BASE_ADDR) >> log2(BPB); low address bits are ignored, so accesses align down. A beat is in range iff addr ≥ BASE_ADDR and index < MEM_DEPTH.
- A request is unsupported if burst ≠ INCR or size ≠ log2(BPB). Unsupported requests complete the full handshake (len+1 beats), never touch memory, and respond SLVERR on every R beat or on B.
- Beat n address = start word index + n. Only the out-of-range beats are affected: W beats are dropped, R beats return data 0 with SLVERR. The 4 kB boundary is not checked.
- Write FSM:
  - WR_IDLE: aw_ready=1. On AW handshake, latch id, word index, len and the unsupported flag; clear the beat counter and error flag; go to WR_DATA.
  - WR_DATA: w_ready=1. On each W handshake, write bytes where w_strb[i]=1 if the beat is in range and the request is supported, then increment the beat counter.
  - The burst ends on beat len+1. If w_last does not match that beat (early or missing), set the error flag and still end on beat len+1. Then go to WR_RESP.
  - WR_RESP: b_valid=1, b_id=latched id, b_resp = SLVERR (2'b10) if any error, else OKAY. Hold until b_ready, then go to WR_IDLE.
- Read FSM:
  - RD_IDLE: ar_ready=1. On AR handshake, latch id, index, len and the unsupported flag; go to RD_DATA.
  - RD_DATA: r_valid=1, r_id=latched id, r_last=1 on beat len. On each R handshake, load the next beat into the r_data/r_resp registers. After the final handshake, go to RD_IDLE.
- b_user, r_user = 0.
- Simultaneous read and write of the same word in the same cycle: the read returns the old value and the write takes effect.
- Memory contents are not reset.

## Timing
- During reset and in the first cycle after release, all outputs are 0: aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, r_data, r_resp, b_resp, b_id, r_id.
- aw_ready and ar_ready rise in the first cycle after reset release. All handshake outputs are registered.
- AW handshake in cycle N → aw_ready=0 and w_ready=1 from N+1.
- Last W handshake in cycle M → w_ready=0 and b_valid=1 from M+1.
- B handshake in cycle K → b_valid=0 and aw_ready=1 from K+1.
- AR handshake in cycle N → r_valid=1 with beat 0 from N+1. Beats stream one per cycle while r_ready=1.
- The R payload (r_data, r_resp, r_last, r_id) is stable while r_valid=1 and r_ready=0.
- Last R handshake in cycle K → r_valid=0, r_last=0 and ar_ready=1 from K+1.
- Valid outputs never drop without a handshake, except on reset.
- Reset mid-burst: both FSMs go to IDLE and all outputs go to their reset values. Memory beats already written are kept.
- Beat counters are 9 bits so that len = 255 (256 beats) works.

## Test plan
- Single write/read: AW 0x10 len0, W 0xDEADBEEF01234567, strb 0xFF, w_last=1 → b_valid at M+1 with OKAY and b_id echoed. AR 0x10 → r_data 0xDEADBEEF01234567, r_last=1, OKAY at N+1.
- INCR burst: AW 0x0 len3, data 1,2,3,4, with beat 2 strb 0x0F over prefill 0xFFFF_FFFF_FFFF_FFFF → read len3 returns 1, 2, 0xFFFFFFFF00000003, 4, with r_last only on beat 3.
- Range edge: AW at word MEM_DEPTH−1, len1 → beat 0 written, beat 1 dropped, bresp SLVERR. AR same → beat 0 OKAY with data, beat 1 SLVERR with data 0.
- Protocol errors: FIXED burst len1 → two W beats accepted, SLVERR, memory unchanged. Separately, a len2 write with w_last on beat 1 → 3 beats accepted, SLVERR.
- Backpressure: b_ready low for 5 cycles → b_valid held and aw_ready=0 throughout. r_ready toggling every cycle on a len7 read → 8 beats in order with stable payload.
- Concurrency/reset: AW and AR to the same word in the same cycle → read returns the old value. rstn_i asserted mid len7 write at beat 3 → all outputs 0, and after release aw_ready=1 and beats 0–2 are readable.

Source files
------------

// File: rtl/axi4_sub_mem_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) with manager and subordinate views.
// Latency: none, wires only.
// Backpressure: carried by the per-channel valid/ready pairs.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
) ();
    // write address channel
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_valid;
    logic                        aw_ready;
    // write data channel
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;
    // write response channel
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;
    // read address channel
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_valid;
    logic                        ar_ready;
    // read data channel
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_sub_mem.sv
// AXI4 subordinate over a word-addressed flop RAM; INCR bursts, SLVERR on bad/out-of-range beats.
// Latency: AW->W ready 1 cycle, last W->B 1 cycle, AR->first R beat 1 cycle, then 1 beat/cycle.
// Backpressure: B and R hold valid and payload until ready; AW/AR not accepted while a burst is open.
module axi4_sub_mem #(
    parameter int unsigned               AXI_ADDR_WIDTH = 32,
    parameter int unsigned               AXI_DATA_WIDTH = 64,
    parameter int unsigned               AXI_ID_WIDTH   = 4,
    parameter int unsigned               MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic  clk_i,
    input  logic  rstn_i,
    AXI_BUS.Slave axi_sub_if
);
    localparam int unsigned BPB     = AXI_DATA_WIDTH / 8;
    localparam int unsigned LOG_BPB = $clog2(BPB);
    localparam int unsigned MAW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned IW      = AXI_ADDR_WIDTH + 1;

    localparam logic [2:0] FULL_SIZE   = 3'(LOG_BPB);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // one extra bit so start index + beat count cannot wrap back into range
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_e;

    function automatic idx_t word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return {1'b0, off >> LOG_BPB};
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write side ----------------
    wr_state_e                 wr_state_q, wr_state_d;
    logic [8:0]                wr_cnt_q, wr_cnt_d;
    logic                      wr_err_q, wr_err_d;
    logic [7:0]                wr_len_q;
    idx_t                      wr_idx_q;
    logic                      wr_below_q, wr_unsup_q;
    logic                      aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]                b_resp_q;
    logic [AXI_ID_WIDTH-1:0]   b_id_q;
    logic                      aw_hs, w_hs, b_hs, aw_unsup;
    idx_t                      wr_beat_idx;
    logic                      wr_beat_ok, wr_beat_last, wr_en;
    logic [MAW-1:0]            wr_mem_addr;

    assign aw_hs        = axi_sub_if.aw_valid && aw_ready_q;
    assign w_hs         = axi_sub_if.w_valid && w_ready_q;
    assign b_hs         = b_valid_q && axi_sub_if.b_ready;
    assign aw_unsup     = (axi_sub_if.aw_burst != BURST_INCR) || (axi_sub_if.aw_size != FULL_SIZE);
    assign wr_beat_idx  = wr_idx_q + idx_t'(wr_cnt_q);
    assign wr_beat_ok   = !wr_below_q && (wr_beat_idx < idx_t'(MEM_DEPTH));
    assign wr_beat_last = (wr_cnt_q == {1'b0, wr_len_q});
    assign wr_mem_addr  = wr_beat_idx[MAW-1:0];

    // write FSM next state: count beats to len+1 regardless of w_last, flag any error
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        wr_en      = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    wr_state_d = WR_DATA;
                    wr_cnt_d   = '0;
                    wr_err_d   = aw_unsup;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    wr_en    = wr_beat_ok && !wr_unsup_q;
                    if (!wr_beat_ok || wr_unsup_q || (axi_sub_if.w_last != wr_beat_last)) begin
                        wr_err_d = 1'b1;
                    end
                    wr_cnt_d = wr_cnt_q + 9'd1;
                    if (wr_beat_last) begin
                        wr_state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // write FSM state plus registered handshake outputs decoded from next state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state_q <= WR_IDLE;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
            wr_len_q   <= '0;
            wr_idx_q   <= '0;
            wr_below_q <= 1'b0;
            wr_unsup_q <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            b_id_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
            aw_ready_q <= (wr_state_d == WR_IDLE);
            w_ready_q  <= (wr_state_d == WR_DATA);
            b_valid_q  <= (wr_state_d == WR_RESP);
            b_resp_q   <= ((wr_state_d == WR_RESP) && wr_err_d) ? RESP_SLVERR : RESP_OKAY;
            if (aw_hs) begin
                b_id_q     <= axi_sub_if.aw_id;
                wr_idx_q   <= word_idx(axi_sub_if.aw_addr);
                wr_below_q <= (axi_sub_if.aw_addr < BASE_ADDR);
                wr_len_q   <= axi_sub_if.aw_len;
                wr_unsup_q <= aw_unsup;
            end
        end
    end

    // byte-enabled memory write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < int'(BPB); i++) begin
                if (axi_sub_if.w_strb[i]) begin
                    mem[wr_mem_addr][i*8 +: 8] <= axi_sub_if.w_data[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_e                 rd_state_q, rd_state_d;
    logic [8:0]                rd_cnt_q, rd_cnt_d;
    logic [7:0]                rd_len_q, rd_len_d;
    idx_t                      rd_idx_q;
    logic                      rd_below_q, rd_unsup_q;
    logic                      ar_ready_q, r_valid_q, r_last_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [1:0]                r_resp_q;
    logic [AXI_ID_WIDTH-1:0]   r_id_q;
    logic                      ar_hs, r_hs, ar_unsup, rd_load;
    idx_t                      fetch_start, fetch_idx;
    logic                      fetch_below, fetch_unsup, fetch_ok;
    logic [8:0]                fetch_cnt;
    logic [AXI_DATA_WIDTH-1:0] fetch_data;
    logic [1:0]                fetch_resp;

    assign ar_hs      = axi_sub_if.ar_valid && ar_ready_q;
    assign r_hs       = r_valid_q && axi_sub_if.r_ready;
    assign ar_unsup   = (axi_sub_if.ar_burst != BURST_INCR) || (axi_sub_if.ar_size != FULL_SIZE);
    assign fetch_idx  = fetch_start + idx_t'(fetch_cnt);
    assign fetch_ok   = !fetch_below && !fetch_unsup && (fetch_idx < idx_t'(MEM_DEPTH));
    assign fetch_data = fetch_ok ? mem[fetch_idx[MAW-1:0]] : '0;
    assign fetch_resp = fetch_ok ? RESP_OKAY : RESP_SLVERR;

    // read FSM next state and selection of the beat to load into the R registers
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_len_d    = rd_len_q;
        rd_load     = 1'b0;
        fetch_start = rd_idx_q;
        fetch_below = rd_below_q;
        fetch_unsup = rd_unsup_q;
        fetch_cnt   = rd_cnt_q + 9'd1;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d  = RD_DATA;
                    rd_cnt_d    = '0;
                    rd_len_d    = axi_sub_if.ar_len;
                    rd_load     = 1'b1;
                    fetch_start = word_idx(axi_sub_if.ar_addr);
                    fetch_below = (axi_sub_if.ar_addr < BASE_ADDR);
                    fetch_unsup = ar_unsup;
                    fetch_cnt   = '0;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    if (rd_cnt_q == {1'b0, rd_len_q}) begin
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 9'd1;
                        rd_load  = 1'b1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // read FSM state plus registered R payload, held steady while r_ready is low
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_len_q   <= '0;
            rd_idx_q   <= '0;
            rd_below_q <= 1'b0;
            rd_unsup_q <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_id_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_len_q   <= rd_len_d;
            ar_ready_q <= (rd_state_d == RD_IDLE);
            r_valid_q  <= (rd_state_d == RD_DATA);
            r_last_q   <= (rd_state_d == RD_DATA) && (rd_cnt_d == {1'b0, rd_len_d});
            if (rd_load) begin
                r_data_q <= fetch_data;
                r_resp_q <= fetch_resp;
            end
            if (ar_hs) begin
                r_id_q     <= axi_sub_if.ar_id;
                rd_idx_q   <= fetch_start;
                rd_below_q <= fetch_below;
                rd_unsup_q <= fetch_unsup;
            end
        end
    end

    assign axi_sub_if.aw_ready = aw_ready_q;
    assign axi_sub_if.w_ready  = w_ready_q;
    assign axi_sub_if.b_valid  = b_valid_q;
    assign axi_sub_if.b_resp   = b_resp_q;
    assign axi_sub_if.b_id     = b_id_q;
    assign axi_sub_if.b_user   = '0;
    assign axi_sub_if.ar_ready = ar_ready_q;
    assign axi_sub_if.r_valid  = r_valid_q;
    assign axi_sub_if.r_last   = r_last_q;
    assign axi_sub_if.r_data   = r_data_q;
    assign axi_sub_if.r_resp   = r_resp_q;
    assign axi_sub_if.r_id     = r_id_q;
    assign axi_sub_if.r_user   = '0;
endmodule

// File: tb/tb_axi4_sub_mem.sv
// Directed bench for axi4_sub_mem: single/burst/range/protocol/backpressure/concurrency/reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled in that same window.
// Every wait on the DUT is bounded; a global watchdog ends a stuck run.
module tb_axi4_sub_mem;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] FIXED  = 2'b00;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    logic [63:0] wd [8];
    logic [7:0]  ws [8];
    logic        wl [8];

    always #5 clk_i = ~clk_i;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

    axi4_sub_mem #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
        .MEM_DEPTH(256), .BASE_ADDR(32'h0)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .axi_sub_if (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_aw_ready"}, bus.aw_ready, 0);
        chk({tag, "_w_ready"},  bus.w_ready,  0);
        chk({tag, "_b_valid"},  bus.b_valid,  0);
        chk({tag, "_ar_ready"}, bus.ar_ready, 0);
        chk({tag, "_r_valid"},  bus.r_valid,  0);
        chk({tag, "_r_last"},   bus.r_last,   0);
        chk({tag, "_r_data"},   bus.r_data,   0);
        chk({tag, "_r_resp"},   bus.r_resp,   0);
        chk({tag, "_b_resp"},   bus.b_resp,   0);
        chk({tag, "_b_id"},     bus.b_id,     0);
        chk({tag, "_r_id"},     bus.r_id,     0);
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst; bus.aw_size = 3'd3;
        bus.aw_id = id; bus.aw_valid = 1'b1;
        while (!bus.aw_ready && n < 50) begin cyc(); n++; end
        chk("aw_ready_wait", bus.aw_ready, 1);
        cyc();
        bus.aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id);
        int n = 0;
        bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst; bus.ar_size = size;
        bus.ar_id = id; bus.ar_valid = 1'b1;
        while (!bus.ar_ready && n < 50) begin cyc(); n++; end
        chk("ar_ready_wait", bus.ar_ready, 1);
        cyc();
        bus.ar_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        bus.w_data = data; bus.w_strb = strb; bus.w_last = last; bus.w_valid = 1'b1;
        while (!bus.w_ready && n < 50) begin cyc(); n++; end
        chk("w_ready_wait", bus.w_ready, 1);
        cyc();
        bus.w_valid = 1'b0;
    endtask

    task automatic b_check(input logic [1:0] resp, input logic [3:0] id, input string tag);
        int n = 0;
        bus.b_ready = 1'b1;
        while (!bus.b_valid && n < 50) begin cyc(); n++; end
        chk({tag, "_b_valid"}, bus.b_valid, 1);
        chk({tag, "_b_resp"},  bus.b_resp,  resp);
        chk({tag, "_b_id"},    bus.b_id,    id);
        cyc();
        bus.b_ready = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] data, input logic [1:0] resp, input logic last, input string tag);
        int n = 0;
        bus.r_ready = 1'b1;
        while (!bus.r_valid && n < 50) begin cyc(); n++; end
        chk({tag, "_r_valid"}, bus.r_valid, 1);
        chk({tag, "_r_data"},  bus.r_data,  data);
        chk({tag, "_r_resp"},  bus.r_resp,  resp);
        chk({tag, "_r_last"},  bus.r_last,  last);
        cyc();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int nb, input logic [1:0] resp, input string tag);
        aw_send(addr, len, burst, id);
        for (int i = 0; i < nb; i++) w_beat(wd[i], ws[i], wl[i]);
        b_check(resp, id, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.b_ready = 0;
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
        bus.r_ready = 0;

        // reset: everything low during reset and in the first cycle after release
        repeat (3) cyc();
        chk_zero("in_reset");
        rstn_i = 1'b1;
        chk_zero("first_cycle");
        cyc();
        chk("post_rst_aw_ready", bus.aw_ready, 1);
        chk("post_rst_ar_ready", bus.ar_ready, 1);

        // single write at 0x10 with cycle-exact channel hand-off
        aw_send(32'h10, 8'd0, INCR, 4'd5);
        chk("single_aw_ready_low", bus.aw_ready, 0);
        chk("single_w_ready_high", bus.w_ready, 1);
        w_beat(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
        chk("single_w_ready_low", bus.w_ready, 0);
        chk("single_b_valid", bus.b_valid, 1);
        chk("single_b_resp", bus.b_resp, OKAY);
        chk("single_b_id", bus.b_id, 5);
        bus.b_ready = 1'b1;
        cyc();
        bus.b_ready = 1'b0;
        chk("single_b_valid_low", bus.b_valid, 0);
        chk("single_aw_ready_back", bus.aw_ready, 1);

        // single read of the same word: beat 0 visible the cycle after AR
        ar_send(32'h10, 8'd0, INCR, 3'd3, 4'd3);
        chk("single_r_valid", bus.r_valid, 1);
        chk("single_r_data", bus.r_data, 64'hDEAD_BEEF_0123_4567);
        chk("single_r_last", bus.r_last, 1);
        chk("single_r_resp", bus.r_resp, OKAY);
        chk("single_r_id", bus.r_id, 3);
        bus.r_ready = 1'b1;
        cyc();
        bus.r_ready = 1'b0;
        chk("single_r_valid_low", bus.r_valid, 0);
        chk("single_r_last_low", bus.r_last, 0);
        chk("single_ar_ready_back", bus.ar_ready, 1);

        // FIXED burst: two beats taken, SLVERR, memory untouched
        wd[0] = 64'h1111; ws[0] = 8'hFF; wl[0] = 1'b0;
        wd[1] = 64'h2222; ws[1] = 8'hFF; wl[1] = 1'b1;
        do_write(32'h10, 8'd1, FIXED, 4'd6, 2, SLVERR, "fixed");
        ar_send(32'h10, 8'd0, INCR, 3'd3, 4'd1);
        r_beat(64'hDEAD_BEEF_0123_4567, OKAY, 1'b1, "fixed_rd");
        bus.r_ready = 1'b0;

        // narrow-size read is unsupported: data 0, SLVERR
        ar_send(32'h10, 8'd0, INCR, 3'd2, 4'd2);
        r_beat(64'h0, SLVERR, 1'b1, "narrow_rd");
        bus.r_ready = 1'b0;

        // INCR burst with a partial-strobe beat over an all-ones prefill
        for (int i = 0; i < 4; i++) begin wd[i] = '1; ws[i] = 8'hFF; wl[i] = (i == 3); end
        do_write(32'h0, 8'd3, INCR, 4'd1, 4, OKAY, "prefill");
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; wl[i] = (i == 3); end
        ws[2] = 8'h0F;
        do_write(32'h0, 8'd3, INCR, 4'd2, 4, OKAY, "burst");
        ar_send(32'h0, 8'd3, INCR, 3'd3, 4'd4);
        r_beat(64'h1, OKAY, 1'b0, "burst_b0");
        r_beat(64'h2, OKAY, 1'b0, "burst_b1");
        r_beat(64'hFFFF_FFFF_0000_0003, OKAY, 1'b0, "burst_b2");
        r_beat(64'h4, OKAY, 1'b1, "burst_b3");
        bus.r_ready = 1'b0;
        chk("burst_r_valid_low", bus.r_valid, 0);

        // range edge: last word in range, next beat off the end
        wd[0] = 64'hA5A5_0000_0000_0001; ws[0] = 8'hFF; wl[0] = 1'b0;
        wd[1] = 64'hA5A5_0000_0000_0002; ws[1] = 8'hFF; wl[1] = 1'b1;
        do_write(32'h7F8, 8'd1, INCR, 4'd7, 2, SLVERR, "edge_wr");
        ar_send(32'h7F8, 8'd1, INCR, 3'd3, 4'd8);
        r_beat(64'hA5A5_0000_0000_0001, OKAY, 1'b0, "edge_b0");
        r_beat(64'h0, SLVERR, 1'b1, "edge_b1");
        bus.r_ready = 1'b0;

        // early w_last: burst still runs to len+1 beats then SLVERR
        aw_send(32'h40, 8'd2, INCR, 4'd9);
        w_beat(64'h10, 8'hFF, 1'b0);
        w_beat(64'h11, 8'hFF, 1'b1);
        chk("early_last_w_ready", bus.w_ready, 1);
        chk("early_last_no_b", bus.b_valid, 0);
        w_beat(64'h12, 8'hFF, 1'b0);
        chk("early_last_w_done", bus.w_ready, 0);
        b_check(SLVERR, 4'd9, "early_last");

        // B backpressure for 5 cycles
        aw_send(32'h18, 8'd0, INCR, 4'd10);
        w_beat(64'h5555_AAAA_0000_1234, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_b_valid_held", bus.b_valid, 1);
            chk("bp_aw_ready_low", bus.aw_ready, 0);
            cyc();
        end
        b_check(OKAY, 4'd10, "bp");

        // len7 burst read with r_ready toggling; payload must hold while stalled
        for (int i = 0; i < 8; i++) begin wd[i] = 64'h100 + 64'(i); ws[i] = 8'hFF; wl[i] = (i == 7); end
        do_write(32'h80, 8'd7, INCR, 4'd11, 8, OKAY, "len7_wr");
        ar_send(32'h80, 8'd7, INCR, 3'd3, 4'd12);
        for (int b = 0; b < 8; b++) begin
            bus.r_ready = 1'b0;
            chk("tog_r_valid", bus.r_valid, 1);
            chk("tog_r_data", bus.r_data, 64'h100 + 64'(b));
            chk("tog_r_last", bus.r_last, (b == 7));
            cyc();
            bus.r_ready = 1'b1;
            chk("tog_hold_data", bus.r_data, 64'h100 + 64'(b));
            chk("tog_hold_last", bus.r_last, (b == 7));
            chk("tog_hold_id", bus.r_id, 12);
            cyc();
        end
        bus.r_ready = 1'b0;
        chk("tog_r_valid_low", bus.r_valid, 0);

        // same-cycle write beat and read fetch of one word: read sees old data
        aw_send(32'h18, 8'd0, INCR, 4'd13);
        bus.w_data = 64'h0000_0000_0000_CAFE; bus.w_strb = 8'hFF; bus.w_last = 1'b1; bus.w_valid = 1'b1;
        bus.ar_addr = 32'h18; bus.ar_len = 8'd0; bus.ar_burst = INCR; bus.ar_size = 3'd3;
        bus.ar_id = 4'd14; bus.ar_valid = 1'b1;
        chk("conc_w_ready", bus.w_ready, 1);
        chk("conc_ar_ready", bus.ar_ready, 1);
        cyc();
        bus.w_valid = 1'b0;
        bus.ar_valid = 1'b0;
        r_beat(64'h5555_AAAA_0000_1234, OKAY, 1'b1, "conc_old");
        bus.r_ready = 1'b0;
        b_check(OKAY, 4'd13, "conc");
        ar_send(32'h18, 8'd0, INCR, 3'd3, 4'd15);
        r_beat(64'h0000_0000_0000_CAFE, OKAY, 1'b1, "conc_new");
        bus.r_ready = 1'b0;

        // reset in the middle of a len7 write, at beat 3
        aw_send(32'h100, 8'd7, INCR, 4'd2);
        for (int i = 0; i < 3; i++) w_beat(64'h30 + 64'(i), 8'hFF, 1'b0);
        bus.w_data = 64'h33; bus.w_strb = 8'hFF; bus.w_last = 1'b0; bus.w_valid = 1'b1;
        rstn_i = 1'b0;
        #1;
        chk_zero("mid_rst");
        bus.w_valid = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
        chk("mid_rst_rel_aw_ready", bus.aw_ready, 0);
        cyc();
        chk("mid_rst_aw_ready", bus.aw_ready, 1);
        chk("mid_rst_ar_ready", bus.ar_ready, 1);
        ar_send(32'h100, 8'd2, INCR, 3'd3, 4'd3);
        r_beat(64'h30, OKAY, 1'b0, "kept_b0");
        r_beat(64'h31, OKAY, 1'b0, "kept_b1");
        r_beat(64'h32, OKAY, 1'b1, "kept_b2");
        bus.r_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
